fifo_rr_scheduler: RTL and testbench

FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

---
 rtl/fifo_rr_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler
//
// Round-robin scheduler that drains NUM_PORTS source FIFOs into a single
// one-entry output register. Each cycle the output register can load, the
// first non-empty FIFO found searching upward from a rotating priority pointer
// is popped. Its read data is captured into the output register on the next
// clock edge.
//
// Optional feature (macro FIFO_RR_BURST_EN): burst mode. After a FIFO wins
// arbitration, it keeps the grant for up to MAX_BURST consecutive words.
//
// Parameters
//   BIT_WIDTH  data width of each source FIFO and of the output word
//   NUM_PORTS  number of source FIFOs (2..16)
//   MAX_BURST  longest run of grants to one port in burst mode (1..16)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   fifo_empty      per-port empty flags (bit i = port i)
//   fifo_read_data  per-port combinational read data, port i at [i*BIT_WIDTH +: BIT_WIDTH]
//   read_en         one-hot (or zero) pop strobe to the source FIFOs
//   out_valid       output register holds a word
//   out_ready       downstream accepts the word this cycle
//   out_data        registered output word
//   out_port        index of the port that supplied out_data
// -----------------------------------------------------------------------------
module fifo_rr_scheduler #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_PORTS = 4,
    parameter int MAX_BURST = 4,
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           fifo_empty,
    input  logic [NUM_PORTS*BIT_WIDTH-1:0] fifo_read_data,
    output logic [NUM_PORTS-1:0]           read_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic [PORT_W-1:0]              out_port
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("fifo_rr_scheduler: NUM_PORTS must be in 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
        $error("fifo_rr_scheduler: MAX_BURST must be in 1..16");
    end

    logic [NUM_PORTS-1:0] req;
    logic                 can_load;
    logic                 rr_valid;
    logic [PORT_W-1:0]    rr_idx;
    logic                 grant_valid;
    logic [PORT_W-1:0]    grant_idx;
    logic [PORT_W-1:0]    ptr;

    assign req      = ~fifo_empty;
    assign can_load = !out_valid || out_ready;

    // Rotating search: the candidate for step k is (ptr + k) mod NUM_PORTS.
    // The first requesting candidate wins.
    always_comb begin : rr_search
        int                idx;
        logic [PORT_W-1:0] cand;
        // NOTE: every combinationally written variable gets a default before
        // any conditional assignment, so no path can leave it holding a value.
        rr_valid = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PORT_W'(idx);
            if (!rr_valid && req[cand]) begin
                rr_valid = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef FIFO_RR_BURST_EN
    typedef enum logic {ARB, BURST} state_t;

    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    state_t              state, state_next;
    logic [PORT_W-1:0]   owner, owner_next;
    logic [BCNT_W-1:0]   bcnt,  bcnt_next;
    logic                burst_hit;

    // The owner keeps the grant while it still has data and its run is short
    // of MAX_BURST.
    assign burst_hit = (state == BURST) && req[owner] && (int'(bcnt) < MAX_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            owner <= '0;
            bcnt  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples values from before the edge, regardless of block order.
            state <= state_next;
            owner <= owner_next;
            bcnt  <= bcnt_next;
        end
    end

    // ptr already equals owner+1 in BURST, because every grant advances ptr.
    // The round-robin search that ends a burst therefore starts after the
    // owner with no extra bookkeeping.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        bcnt_next   = bcnt;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (can_load) begin
            if (burst_hit) begin
                grant_valid = 1'b1;
                grant_idx   = owner;
                bcnt_next   = bcnt + 1'b1;
            end else if (rr_valid) begin
                grant_valid = 1'b1;
                grant_idx   = rr_idx;
                state_next  = BURST;
                owner_next  = rr_idx;
                bcnt_next   = BCNT_W'(1);
            end else begin
                state_next  = ARB;
                bcnt_next   = '0;
            end
        end
    end
`else
    assign grant_valid = can_load && rr_valid;
    assign grant_idx   = rr_idx;
`endif

    // Pops are suppressed while reset is held. The output register is
    // already empty in that state, so it would otherwise look loadable.
    always_comb begin
        read_en = '0;
        if (grant_valid && !rst) read_en[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: out_data is a single register, not a memory array, so it
            // is cleared on reset to give a known value while out_valid is 0.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            ptr       <= '0;
        end else if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= fifo_read_data[grant_idx*BIT_WIDTH +: BIT_WIDTH];
            out_port  <= grant_idx;
            ptr       <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
module tb_fifo_rr_scheduler;
    localparam int BW = 8;
    localparam int NP = 4;
    localparam int MB = 4;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     fifo_empty;
    logic [NP*BW-1:0]  fifo_read_data;
    logic [NP-1:0]     read_en;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out_data;
    logic [PW-1:0]     out_port;

    fifo_rr_scheduler #(.BIT_WIDTH(BW), .NUM_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .read_en        (read_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_port       (out_port)
    );

    always #5 clk = ~clk;

    // Source FIFO contents, owned by the bench.
    logic [BW-1:0] q [NP][$];
    int            seq [NP];

    int total = 0;
    int bad   = 0;

    // Behavioural model state: output register, rotating pointer, burst run.
    bit            m_valid;
    logic [BW-1:0] m_data;
    int            m_port, m_ptr, m_owner, m_cnt;
    int            pend = -1;

    int grant_log[$];
    int port_log[$];
    int exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < NP; p++) begin
            fifo_empty[p] = (q[p].size() == 0);
            fifo_read_data[p*BW +: BW] = (q[p].size() > 0) ? q[p][0] : '0;
        end
    endtask

    task automatic load(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            q[p].push_back(BW'(16 * (p + 1) + seq[p]));
            seq[p]++;
        end
        refresh();
    endtask

    // Model evaluation and comparison, run at the falling edge.
    task automatic model_check();
        int            g;
        int            p;
        bit            hit;
        bit            cl;
        logic [NP-1:0] exp_re;
        g = -1;
        hit = 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_port = 0; m_ptr = 0;
            m_owner = 0; m_cnt = 0; pend = -1;
        end
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data",  64'(out_data),  64'(m_data));
        check("out_port",  64'(out_port),  64'(m_port));
        cl = !m_valid || out_ready;
        if (!rst && cl) begin
`ifdef FIFO_RR_BURST_EN
            if (m_cnt > 0 && m_cnt < MB && q[m_owner].size() > 0) begin
                g = m_owner;
                hit = 1'b1;
            end
`endif
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (g < 0 && q[p].size() > 0) g = p;
            end
        end
        exp_re = (g >= 0) ? (NP'(1) << g) : '0;
        check("read_en", 64'(read_en), 64'(exp_re));
        check("no_underflow", 64'(read_en & fifo_empty), 64'(0));
        for (int i = 0; i < NP; i++) if (read_en[i]) grant_log.push_back(i);
        if (!rst && out_valid && out_ready) port_log.push_back(int'(out_port));
        if (g >= 0) begin
            m_data  = q[g][0];
            m_port  = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NP;
            if (hit) m_cnt++;
            else begin
                m_owner = g;
                m_cnt   = 1;
            end
            pend = g;
        end else if (cl) begin
            if (m_valid && out_ready) m_valid = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        if (pend >= 0) begin
            q[pend].delete(0);
            pend = -1;
        end
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic clear_logs();
        grant_log.delete();
        port_log.delete();
    endtask

    logic [BW-1:0] held_word;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) seq[p] = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        fifo_empty = '1;
        fifo_read_data = '0;
        for (int p = 0; p < NP; p++) load(p, 3);
        @(posedge clk);
        #1;

        // Reset with every FIFO non-empty.
        steps(3);
        check("rst_read_en",   64'(read_en),   64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_port",  64'(out_port),  64'(0));

        // All ports busy, downstream always ready.
        rst = 1'b0;
        clear_logs();
        steps(15);
`ifdef FIFO_RR_BURST_EN
        exp_q = '{0,0,0,1,1,1,2,2,2,3,3,3};
`else
        exp_q = '{0,1,2,3,0,1,2,3,0,1,2,3};
`endif
        check_log("rr_grants", grant_log, exp_q);
        check_log("rr_ports", port_log, exp_q);

        // Backpressure: hold for three cycles, then release.
        out_ready = 1'b0;
        load(1, 4);
        load(3, 4);
        held_word = q[1][0];
        clear_logs();
        step();
        exp_q = '{1};
        check_log("bp_first", grant_log, exp_q);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_read_en",   64'(read_en),   64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data",  64'(out_data),  64'(held_word));
            check("bp_out_port",  64'(out_port),  64'(1));
        end
        out_ready = 1'b1;
        step();
`ifdef FIFO_RR_BURST_EN
        exp_q = '{1,1};
`else
        exp_q = '{1,3};
`endif
        check_log("bp_release", grant_log, exp_q);
        steps(10);

        // Single requester with the pointer parked past it.
        load(2, 1);
        steps(4);
        load(2, 5);
        clear_logs();
        steps(8);
        exp_q = '{2,2,2,2,2};
        check_log("single_port", grant_log, exp_q);
        check("single_idle", 64'(read_en), 64'(0));

        // Two ports with six words each.
        load(0, 6);
        load(1, 6);
        clear_logs();
        steps(15);
`ifdef FIFO_RR_BURST_EN
        exp_q = '{0,0,0,0,1,1,1,1,0,0,1,1};
`else
        exp_q = '{0,1,0,1,0,1,0,1,0,1,0,1};
`endif
        check_log("two_port", grant_log, exp_q);

        // Reset while a word is held.
        out_ready = 1'b0;
        load(2, 2);
        steps(2);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_valid",   64'(out_valid), 64'(0));
        check("mid_rst_data",    64'(out_data),  64'(0));
        check("mid_rst_port",    64'(out_port),  64'(0));
        check("mid_rst_read_en", 64'(read_en),   64'(0));
        steps(2);
        rst = 1'b0;
        out_ready = 1'b1;
        load(0, 1);
        load(3, 1);
        clear_logs();
        steps(6);
        exp_q = '{0,2,3};
        check_log("post_rst", grant_log, exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
